// File: rtl/aibio_dll_pkg.sv
// Shared types for the AIB I/O DLL lock controller: FSM state and window decision encodings.
package aibio_dll_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_ACC    = 3'd2,
      ST_SEARCH = 3'd3,
      ST_TRACK  = 3'd4
   } dll_state_e;

   typedef enum logic [1:0] {
      DCN_BAL = 2'd0,
      DCN_INC = 2'd1,
      DCN_DEC = 2'd2
   } dll_dcn_e;

   // Bits needed to hold values 0..max_val, never less than one.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      int unsigned w;
      w = $clog2(max_val + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/aibio_dll_vote_acc.sv
// Phase-detector vote accumulator over a 2**WIN_LOG2 cycle window with dead-band decision.
module aibio_dll_vote_acc
   import aibio_dll_pkg::*;
#(
   parameter int unsigned WIN_LOG2 = 4,
   parameter int unsigned THR      = 2
) (
   input  logic     i_clk,
   input  logic     clear,
   input  logic     enable,
   input  logic     up,
   input  logic     dn,
   output logic     win_done_c,
   output dll_dcn_e decision_c
);

   localparam int unsigned ACC_W = WIN_LOG2 + 2;
   localparam logic signed [ACC_W-1:0] THR_POS = ACC_W'(THR);
   localparam logic signed [ACC_W-1:0] THR_NEG = -THR_POS;

   logic [WIN_LOG2-1:0]     win_cnt_q;
   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] vote_c;
   logic signed [ACC_W-1:0] net_c;

   // Net includes the current cycle's vote so the decision is ready on the last window cycle.
   always_comb begin
      vote_c = '0;
      if (up && !dn) begin
         vote_c = ACC_W'(1);
      end else if (dn && !up) begin
         vote_c = '1;
      end
      net_c      = acc_q + vote_c;
      win_done_c = enable && (win_cnt_q == '1);
      decision_c = DCN_BAL;
      if (net_c > THR_POS) begin
         decision_c = DCN_INC;
      end else if (net_c < THR_NEG) begin
         decision_c = DCN_DEC;
      end
   end

   always_ff @(posedge i_clk) begin
      if (clear) begin
         win_cnt_q <= '0;
         acc_q     <= '0;
      end else if (enable) begin
         win_cnt_q <= win_cnt_q + WIN_LOG2'(1);
         acc_q     <= net_c;
      end
   end

endmodule

// File: rtl/aibio_dll_lock_ctrl.sv
// DLL lock controller: binary search of the delay code, then +/-1 tracking with lock
// qualification and sticky saturation reporting.
module aibio_dll_lock_ctrl
   import aibio_dll_pkg::*;
#(
   parameter int unsigned CODE_W     = 5,
   parameter int unsigned WIN_LOG2   = 4,
   parameter int unsigned SETTLE_CYC = 8,
   parameter int unsigned THR        = 2,
   parameter int unsigned LOCK_CNT   = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_up,
   input  logic              i_dn,
   output logic [CODE_W-1:0] o_dll_capctrl,
   output logic              o_dll_en,
   output logic              o_lock,
   output logic              o_sat_err,
   output logic [2:0]        o_state
);

   localparam int unsigned STEP_W = CODE_W - 1;
   localparam int unsigned SET_W  = cnt_width(SETTLE_CYC);
   localparam int unsigned BAL_W  = cnt_width(LOCK_CNT);

   localparam logic [CODE_W-1:0] CODE_MID  = CODE_W'(1 << (CODE_W - 1));
   localparam logic [CODE_W-1:0] CODE_MAX  = '1;
   localparam logic [STEP_W-1:0] STEP_INIT = STEP_W'(1 << (CODE_W - 2));
   localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_CYC - 1);
   localparam logic [BAL_W-1:0]  BAL_FULL  = BAL_W'(LOCK_CNT);

   dll_state_e        state_q, state_d;
   dll_dcn_e          dcn_q, dcn_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [SET_W-1:0]  settle_q, settle_d;
   logic [BAL_W-1:0]  bal_q, bal_d, bal_inc_c;
   logic              srch_q, srch_d;
   logic              lock_q, lock_d;
   logic              sat_q, sat_d;
   logic              en_q, en_d;

   logic              acc_clear_c;
   logic              acc_en_c;
   logic              win_done_c;
   dll_dcn_e          decision_c;

   logic [CODE_W-1:0] adj_delta_c;
   logic [CODE_W:0]   adj_sum_c;
   logic [CODE_W-1:0] adj_code_c;
   logic              adj_clamp_c;

   assign acc_clear_c = i_rst || !i_start || (state_q != ST_ACC);
   assign acc_en_c    = (state_q == ST_ACC);

   aibio_dll_vote_acc #(
      .WIN_LOG2 (WIN_LOG2),
      .THR      (THR)
   ) u_vote_acc (
      .i_clk      (i_clk),
      .clear      (acc_clear_c),
      .enable     (acc_en_c),
      .up         (i_up),
      .dn         (i_dn),
      .win_done_c (win_done_c),
      .decision_c (decision_c)
   );

   // Clamped code adjustment: search moves by step, tracking moves by one.
   always_comb begin
      adj_delta_c = (state_q == ST_SEARCH) ? CODE_W'(step_q) : CODE_W'(1);
      adj_sum_c   = {1'b0, code_q} + {1'b0, adj_delta_c};
      adj_code_c  = code_q;
      adj_clamp_c = 1'b0;
      case (dcn_q)
         DCN_INC: begin
            if (adj_sum_c > {1'b0, CODE_MAX}) begin
               adj_code_c  = CODE_MAX;
               adj_clamp_c = 1'b1;
            end else begin
               adj_code_c = adj_sum_c[CODE_W-1:0];
            end
         end
         DCN_DEC: begin
            if (adj_delta_c > code_q) begin
               adj_code_c  = '0;
               adj_clamp_c = 1'b1;
            end else begin
               adj_code_c = code_q - adj_delta_c;
            end
         end
         default: begin
            adj_code_c = code_q;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!i_start) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:   state_d = ST_SETTLE;
            ST_SETTLE: if (settle_q == SET_LAST) state_d = ST_ACC;
            ST_ACC:    if (win_done_c) state_d = srch_q ? ST_SEARCH : ST_TRACK;
            ST_SEARCH: state_d = ST_SETTLE;
            ST_TRACK:  state_d = (adj_code_c != code_q) ? ST_SETTLE : ST_ACC;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   // Next values for the registered outputs and datapath.
   always_comb begin
      code_d    = code_q;
      step_d    = step_q;
      srch_d    = srch_q;
      lock_d    = lock_q;
      sat_d     = sat_q;
      bal_d     = bal_q;
      dcn_d     = dcn_q;
      en_d      = (state_d != ST_IDLE);
      settle_d  = ((state_q == ST_SETTLE) && (state_d == ST_SETTLE)) ? settle_q + SET_W'(1) : '0;
      bal_inc_c = (bal_q == BAL_FULL) ? bal_q : bal_q + BAL_W'(1);
      if (!i_start) begin
         lock_d = 1'b0;
         bal_d  = '0;
         step_d = '0;
         srch_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               code_d = CODE_MID;
               step_d = STEP_INIT;
               srch_d = 1'b1;
               sat_d  = 1'b0;
               lock_d = 1'b0;
               bal_d  = '0;
            end
            ST_ACC: begin
               if (win_done_c) dcn_d = decision_c;
            end
            ST_SEARCH: begin
               code_d = adj_code_c;
               if (adj_clamp_c) sat_d = 1'b1;
               step_d = step_q >> 1;
               if ((step_q >> 1) == '0) srch_d = 1'b0;
            end
            ST_TRACK: begin
               code_d = adj_code_c;
               if (adj_clamp_c) sat_d = 1'b1;
               if (dcn_q == DCN_BAL) begin
                  bal_d  = bal_inc_c;
                  lock_d = (bal_inc_c == BAL_FULL);
               end else begin
                  bal_d  = '0;
                  lock_d = 1'b0;
               end
            end
            default: begin
               code_d = code_q;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         code_q   <= CODE_MID;
         step_q   <= '0;
         srch_q   <= 1'b0;
         lock_q   <= 1'b0;
         sat_q    <= 1'b0;
         en_q     <= 1'b0;
         bal_q    <= '0;
         settle_q <= '0;
         dcn_q    <= DCN_BAL;
      end else begin
         code_q   <= code_d;
         step_q   <= step_d;
         srch_q   <= srch_d;
         lock_q   <= lock_d;
         sat_q    <= sat_d;
         en_q     <= en_d;
         bal_q    <= bal_d;
         settle_q <= settle_d;
         dcn_q    <= dcn_d;
      end
   end

   assign o_dll_capctrl = code_q;
   assign o_dll_en      = en_q;
   assign o_lock        = lock_q;
   assign o_sat_err     = sat_q;
   assign o_state       = state_q;

endmodule

// File: doc/aibio_dll_lock_ctrl.md
AIBIO_DLL_LOCK_CTRL -- requirements
Module: aibio_dll_lock_ctrl

Interface
REQ-001 SHALL have parameter CODE_W, default 5: width of the delay-line capacitor control code.
REQ-002 SHALL have parameter WIN_LOG2, default 4: vote window length is 2**WIN_LOG2 cycles.
REQ-003 SHALL have parameter SETTLE_CYC, default 8: cycles to wait after any code change.
REQ-004 SHALL have parameter THR, default 2: dead-band on the net vote.
REQ-005 SHALL have parameter LOCK_CNT, default 4: consecutive balanced TRACK windows needed for lock.
REQ-006 SHALL have port i_clk, input, 1: sole clock.
REQ-007 SHALL have port i_rst, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port i_start, input, 1: level; high = calibrate/track, low = abort to IDLE.
REQ-009 SHALL have port i_up, input, 1: phase-detector up vote, already synchronous to i_clk.
REQ-010 SHALL have port i_dn, input, 1: phase-detector down vote, already synchronous to i_clk.
REQ-011 SHALL have port o_dll_capctrl, output, CODE_W: delay code.
REQ-012 SHALL have port o_dll_en, output, 1: DLL enable, high in every state except IDLE.
REQ-013 SHALL have port o_lock, output, 1: lock status.
REQ-014 SHALL have port o_sat_err, output, 1: sticky saturation error.
REQ-015 SHALL have port o_state, output, 3: current FSM state encoding.

Function
REQ-016 FSM states SHALL be IDLE, SETTLE, ACC, SEARCH, TRACK.
- IDLE -> SETTLE when i_start=1.
- On leaving IDLE: code = 2**(CODE_W-1), step = 2**(CODE_W-2), search flag = 1.
REQ-017 SETTLE SHALL last exactly SETTLE_CYC cycles and then go to ACC; the vote accumulator is cleared on entry to ACC.
REQ-018 ACC SHALL last exactly 2**WIN_LOG2 cycles. Per-cycle vote:
- up=1, dn=0: +1
- dn=1, up=0: -1
- both equal: 0
- Net vote is signed, width WIN_LOG2+2.
REQ-019 Decision at end of window:
- net > THR: INC
- net < -THR: DEC
- otherwise: BAL
- Next state is SEARCH if the search flag is set, else TRACK.
REQ-020 SEARCH, one cycle:
- INC adds step; DEC subtracts step; BAL leaves the code unchanged.
- step then halves.
- If the new step is 0: clear the search flag.
- Always go to SETTLE.
REQ-021 TRACK, one cycle:
- INC/DEC change the code by 1; INC/DEC also clear the balanced counter and o_lock.
- BAL increments the balanced counter, saturating at LOCK_CNT.
- o_lock is set when the counter reaches LOCK_CNT.
- Then go to SETTLE, or to ACC if the code did not change.
REQ-022 The code SHALL clamp to [0, 2**CODE_W-1]. A clamped INC at max or DEC at 0 SHALL set o_sat_err, which stays set until reset or a new IDLE exit.
REQ-023 i_start=0 in any state SHALL go to IDLE next cycle:
- o_dll_en = 0, o_lock = 0
- counters cleared
- o_dll_capctrl holds its last value
REQ-024 o_dll_capctrl and o_lock SHALL be registered outputs that change only at SEARCH/TRACK/IDLE transitions, never inside ACC or SETTLE.

Reset
REQ-025 While i_rst=1 at a clock edge:
- state = IDLE
- o_dll_capctrl = 2**(CODE_W-1)
- o_dll_en = 0, o_lock = 0, o_sat_err = 0
- all counters and the accumulator = 0
REQ-026 Reset SHALL take priority over i_start and over any in-progress window.

Structure
REQ-027 Package aibio_dll_pkg SHALL hold the state enum (3 bits) and the decision enum (INC/DEC/BAL).
REQ-028 The vote accumulator and window counter SHALL be one sub-module, aibio_dll_vote_acc, with ports:
- inputs: clear, enable, up, dn
- outputs: window done, decision
REQ-029 All widths SHALL derive from the parameters; no hard-coded 5-bit assumptions.

Verification
REQ-030 Defaults, i_up=1, i_dn=0 constant: code steps 16 -> 24 -> 28 -> 30 -> 31; in TRACK, o_sat_err=1 and code stays 31; o_lock stays 0.
REQ-031 Defaults, i_up=i_dn (alternating or both high): code stays 16 through search; o_lock rises after 4 TRACK windows.
REQ-032 Net vote exactly +2 per window: decision BAL (dead-band edge). Net vote +3: INC.
REQ-033 Drop i_start mid-ACC after lock at code 20: next cycle state IDLE, o_lock=0, o_dll_en=0, code 20; re-raise i_start: code returns to 16.
REQ-034 Assert i_rst mid-SEARCH: next cycle all outputs at their reset values; CODE_W=7 rerun starts the search at code 64 with step 32.
